// File: rtl/sdram_rom_loader.sv
// Packs the byte-wide ioctl ROM download into 16-bit SDRAM writes on two toggle-handshake ports.
// Optional feature macro DL_CHECKSUM_EN: 16-bit wraparound byte sum on dl_sum_o (tied to zero otherwise).
module sdram_rom_loader #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] BANK2_BASE = 25'h400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_downl_i,
    input  logic        ioctl_wr_i,
    input  logic [24:0] ioctl_addr_i,
    input  logic [7:0]  ioctl_dout_i,
    output logic        ioctl_wait_o,
    output logic        port1_req_o,
    input  logic        port1_ack_i,
    output logic        port2_req_o,
    input  logic        port2_ack_i,
    output logic        port_we_o,
    output logic [22:0] port_a_o,
    output logic [1:0]  port_ds_o,
    output logic [15:0] port_d_o,
    output logic        dl_done_o,
    output logic [15:0] dl_sum_o
);
    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] WAIT_THR = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [23:0]   B2_WA    = BANK2_BASE[24:1];

    typedef struct packed {
        logic [23:0] wa;
        logic [15:0] d;
        logic [1:0]  ds;
    } word_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    word_t         fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    word_t         pair_q, pair_d;
    logic          pair_vld_q, pair_vld_d;
    state_t        state_q, state_d;
    logic          p1_req_q, p2_req_q, sel_q;
    logic [22:0]   port_a_q;
    logic [1:0]    port_ds_q;
    logic [15:0]   port_d_q;
    logic          downl_q, armed_q, dl_done_q;

    logic  byte_acc, fifo_full, flush_pend, push, push_en, pop, ack_match, dl_rise, done_cond;
    logic  head_p2;
    word_t push_dat, head;

    assign fifo_full    = (count_q == FULL_CNT);
    assign flush_pend   = !ioctl_downl_i && pair_vld_q;
    assign ioctl_wait_o = (count_q >= WAIT_THR) || flush_pend;
    assign byte_acc     = ioctl_wr_i && !ioctl_wait_o;
    assign push_en      = push && !fifo_full;

    // Byte packing: at most one FIFO push per cycle; a second word parks in the pair register.
    always_comb begin
        push       = 1'b0;
        push_dat   = pair_q;
        pair_d     = pair_q;
        pair_vld_d = pair_vld_q;
        if (byte_acc) begin
            if (!ioctl_addr_i[0]) begin
                push       = pair_vld_q;
                pair_vld_d = 1'b1;
                pair_d     = '{ioctl_addr_i[24:1], {8'h00, ioctl_dout_i}, 2'b01};
            end else if (pair_vld_q && pair_q.wa == ioctl_addr_i[24:1] && pair_q.ds == 2'b01) begin
                push       = 1'b1;
                push_dat   = '{ioctl_addr_i[24:1], {ioctl_dout_i, pair_q.d[7:0]}, 2'b11};
                pair_vld_d = 1'b0;
            end else if (pair_vld_q) begin
                push   = 1'b1;
                pair_d = '{ioctl_addr_i[24:1], {ioctl_dout_i, 8'h00}, 2'b10};
            end else begin
                push     = 1'b1;
                push_dat = '{ioctl_addr_i[24:1], {ioctl_dout_i, 8'h00}, 2'b10};
            end
        end else if (flush_pend && !fifo_full) begin
            push       = 1'b1;
            pair_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) fifo_q[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pair_q     <= '0;
            pair_vld_q <= 1'b0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_q + CW'(push_en) - CW'(pop);
            pair_q     <= pair_d;
            pair_vld_q <= pair_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign ack_match = sel_q ? (port2_ack_i == p2_req_q) : (port1_ack_i == p1_req_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (count_q != '0) state_d = ISSUE;
            ISSUE:    state_d = WAIT_ACK;
            WAIT_ACK: if (ack_match) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        pop = (state_q == ISSUE);
    end

    assign head    = fifo_q[rd_ptr_q];
    assign head_p2 = (head.wa >= B2_WA);

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_req_q  <= 1'b0;
            p2_req_q  <= 1'b0;
            sel_q     <= 1'b0;
            port_a_q  <= '0;
            port_ds_q <= '0;
            port_d_q  <= '0;
        end else if (pop) begin
            sel_q     <= head_p2;
            port_a_q  <= 23'(head_p2 ? (head.wa - B2_WA) : head.wa);
            port_ds_q <= head.ds;
            port_d_q  <= head.d;
            if (head_p2) p2_req_q <= ~p2_req_q;
            else         p1_req_q <= ~p1_req_q;
        end
    end

    assign dl_rise   = ioctl_downl_i && !downl_q;
    assign done_cond = armed_q && !ioctl_downl_i && !pair_vld_q && (count_q == '0)
                       && (state_q == IDLE) && !byte_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            downl_q   <= 1'b0;
            armed_q   <= 1'b0;
            dl_done_q <= 1'b0;
        end else begin
            downl_q   <= ioctl_downl_i;
            dl_done_q <= done_cond;
            if (dl_rise)        armed_q <= 1'b1;
            else if (done_cond) armed_q <= 1'b0;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] sum_q;
    always_ff @(posedge clk) begin
        if (reset || dl_rise) sum_q <= '0;
        else if (byte_acc)    sum_q <= sum_q + {8'h00, ioctl_dout_i};
    end
    assign dl_sum_o = sum_q;
`else
    assign dl_sum_o = 16'h0000;
`endif

    assign port1_req_o = p1_req_q;
    assign port2_req_o = p2_req_q;
    assign port_we_o   = 1'b1;
    assign port_a_o    = port_a_q;
    assign port_ds_o   = port_ds_q;
    assign port_d_o    = port_d_q;
    assign dl_done_o   = dl_done_q;
endmodule

// File: tb/tb_sdram_rom_loader.sv
// Directed bench for sdram_rom_loader with a delayed-ack controller model and a write monitor.
module tb_sdram_rom_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_downl = 1'b0, ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait, port1_req, port2_req, port_we, dl_done;
    logic        port1_ack, port2_ack;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;
    logic [15:0] dl_sum;

    int nvec = 0, nerr = 0;
    int ack_dly = 2, ack_cnt = 0;
    int done_cnt = 0;
    bit in_rst = 1'b1, wait_seen = 1'b0;
    logic p1_prev = 1'b0, p2_prev = 1'b0;
    logic [41:0] wq[$];

    sdram_rom_loader dut (
        .clk(clk), .reset(reset),
        .ioctl_downl_i(ioctl_downl), .ioctl_wr_i(ioctl_wr), .ioctl_addr_i(ioctl_addr),
        .ioctl_dout_i(ioctl_dout), .ioctl_wait_o(ioctl_wait),
        .port1_req_o(port1_req), .port1_ack_i(port1_ack),
        .port2_req_o(port2_req), .port2_ack_i(port2_ack),
        .port_we_o(port_we), .port_a_o(port_a), .port_ds_o(port_ds), .port_d_o(port_d),
        .dl_done_o(dl_done), .dl_sum_o(dl_sum)
    );

    always #5 clk = ~clk;

    // Controller model: acknowledges the outstanding toggle after ack_dly cycles.
    always @(posedge clk) begin
        if (reset) begin
            port1_ack <= 1'b0;
            port2_ack <= 1'b0;
            ack_cnt   <= 0;
        end else if (port1_req != port1_ack || port2_req != port2_ack) begin
            if (ack_cnt >= ack_dly) begin
                port1_ack <= port1_req;
                port2_ack <= port2_req;
                ack_cnt   <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!in_rst) begin
            if (port1_req !== p1_prev) wq.push_back({1'b0, port_a, port_ds, port_d});
            if (port2_req !== p2_prev) wq.push_back({1'b1, port_a, port_ds, port_d});
            if (dl_done) done_cnt++;
            if (ioctl_wait) wait_seen = 1'b1;
            if (ioctl_wr) assert (!ioctl_wait) else $error("FAIL strobe_under_wait: wait=%b required 0", ioctl_wait);
        end
        p1_prev = port1_req;
        p2_prev = port2_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("wait_timeout", {31'd0, ioctl_wait}, 32'd0);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (dl_done) found = 1'b1;
        end
        chk(tag, {31'd0, dl_done}, 32'd1);
        cycles(3);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic p, input logic [22:0] a,
                          input logic [15:0] d, input logic [1:0] ds);
        logic [41:0] e;
        e = (idx < wq.size()) ? wq[idx] : '1;
        chk({tag, "_port"}, {31'd0, e[41]}, {31'd0, p});
        chk({tag, "_a"},    {9'd0, e[40:18]}, {9'd0, a});
        chk({tag, "_d_ds"}, {14'd0, e[15:0], e[17:16]}, {14'd0, d, ds});
    endtask

    initial begin
        cycles(2);
        chk("rst_req1", {31'd0, port1_req}, 32'd0);
        chk("rst_req2", {31'd0, port2_req}, 32'd0);
        chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("rst_done_sum", {15'd0, dl_done, dl_sum}, 32'd0);
        reset = 1'b0;
        in_rst = 1'b0;
        cycles(2);

        // Full word to port1
        wq.delete();
        ioctl_downl = 1'b1;
        cycles(1);
        send_byte(25'h0, 8'h11);
        send_byte(25'h1, 8'h22);
        ioctl_downl = 1'b0;
        wait_done("t1_done");
        chk("t1_nwr", wq.size(), 32'd1);
        chk_wr("t1_w0", 0, 1'b0, 23'h0, 16'h2211, 2'b11);
        chk("t1_done_cnt", done_cnt, 32'd1);

        // Lone odd byte to port2, flushed by downl falling
        wq.delete();
        ioctl_downl = 1'b1;
        cycles(1);
        send_byte(25'h400005, 8'hAB);
        ioctl_downl = 1'b0;
        wait_done("t2_done");
        chk("t2_nwr", wq.size(), 32'd1);
        chk_wr("t2_w0", 0, 1'b1, 23'h2, 16'hAB00, 2'b10);

        // Even byte then odd byte in a different word, second word flushed
        wq.delete();
        ioctl_downl = 1'b1;
        cycles(1);
        send_byte(25'h8, 8'h5A);
        send_byte(25'h21, 8'h77);
        ioctl_downl = 1'b0;
        wait_done("t3_done");
        chk("t3_nwr", wq.size(), 32'd2);
        chk_wr("t3_w0", 0, 1'b0, 23'h4, 16'h005A, 2'b01);
        chk_wr("t3_w1", 1, 1'b0, 23'h10, 16'h7700, 2'b10);

        // Slow controller, streaming source throttled by ioctl_wait
        wq.delete();
        ack_dly = 20;
        wait_seen = 1'b0;
        ioctl_downl = 1'b1;
        cycles(1);
        for (int k = 0; k < 16; k++) send_byte(25'h100 + 25'(k), 8'(8'h30 + k));
        ioctl_downl = 1'b0;
        wait_done("t4_done");
        chk("t4_wait_seen", {31'd0, wait_seen}, 32'd1);
        chk("t4_nwr", wq.size(), 32'd8);
        for (int w = 0; w < 8; w++)
            chk_wr($sformatf("t4_w%0d", w), w, 1'b0, 23'h80 + 23'(w),
                   {8'(8'h31 + 2 * w), 8'(8'h30 + 2 * w)}, 2'b11);

        // Reset while a request is outstanding
        wq.delete();
        ack_dly = 1000;
        ioctl_downl = 1'b1;
        cycles(1);
        for (int k = 0; k < 4; k++) send_byte(25'(k), 8'(8'hC0 + k));
        cycles(4);
        chk("t5_req_pending", {31'd0, port1_req ^ port1_ack}, 32'd1);
        in_rst = 1'b1;
        reset = 1'b1;
        ioctl_downl = 1'b0;
        cycles(1);
        chk("t5_rst_reqs", {30'd0, port1_req, port2_req}, 32'd0);
        chk("t5_rst_wait_done", {30'd0, ioctl_wait, dl_done}, 32'd0);
        reset = 1'b0;
        ack_dly = 2;
        cycles(1);
        in_rst = 1'b0;
        wq.delete();
        done_cnt = 0;
        cycles(30);
        chk("t5_no_writes", wq.size(), 32'd0);
        chk("t5_no_done", done_cnt, 32'd0);

        // Checksum
        wq.delete();
        ioctl_downl = 1'b1;
        cycles(1);
        send_byte(25'h10, 8'hFF);
        send_byte(25'h11, 8'h02);
        ioctl_downl = 1'b0;
        wait_done("t6_done");
        chk_wr("t6_w0", 0, 1'b0, 23'h8, 16'h02FF, 2'b11);
`ifdef DL_CHECKSUM_EN
        chk("t6_sum", {16'd0, dl_sum}, 32'h0101);
`else
        chk("t6_sum", {16'd0, dl_sum}, 32'h0000);
`endif
        chk("we_const", {31'd0, port_we}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
